// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// Optional same-cycle read forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_ADDR_W = 4;

  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

  // Byte-enable vector of one write port at the default data width.
  typedef logic [byte_lanes(REGFILE_DATA_W)-1:0] be_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: writes clear, reservations set, and a reservation wins on a tie.
// With REGFILE_BYPASS_EN defined, rbusy shows the post-edge busy value.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2**ADDR_W-1:0]     wclr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD-1:0]        rbusy,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // The set is applied after the clear so a new producer supersedes the retiring one.
  always_comb begin
    busy_d = busy_q & ~wclr;
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
`ifdef REGFILE_BYPASS_EN
      rbusy[i] = rst_n & busy_d[raddr[i*ADDR_W +: ADDR_W]];
`else
      rbusy[i] = busy_q[raddr[i*ADDR_W +: ADDR_W]];
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with byte-enable writes, optional zero register
// and a busy scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]         raddr,
  output logic [NUM_RD*DATA_W-1:0]         rdata,
  output logic [NUM_RD-1:0]                rbusy,
  input  logic [NUM_WR-1:0]                wen,
  input  logic [NUM_WR*ADDR_W-1:0]         waddr,
  input  logic [NUM_WR*(DATA_W/8)-1:0]     wbe,
  input  logic [NUM_WR*DATA_W-1:0]         wdata,
  input  logic                             rsv_en,
  input  logic [ADDR_W-1:0]                rsv_addr,
  output logic [2**ADDR_W-1:0]             busy_vec
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int BE_W  = byte_lanes(DATA_W);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [ADDR_W-1:0]            wa [NUM_WR];
  logic [DEPTH-1:0]             wclr;

  always_comb begin
    for (int j = 0; j < NUM_WR; j++) wa[j] = waddr[j*ADDR_W +: ADDR_W];
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    wclr = '0;
    for (int j = 0; j < NUM_WR; j++)
      if (wen[j]) wclr[wa[j]] = 1'b1;
  end

  // NOTE: the array is reset because reads must return 0 after reset; this keeps it in flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else begin
      // NOTE: non-blocking updates in port order; the last one scheduled (higher port) wins a byte.
      for (int j = 0; j < NUM_WR; j++)
        for (int b = 0; b < BE_W; b++)
          if (wen[j] && wbe[j*BE_W + b] && !(ZERO_REG != 0 && wa[j] == '0))
            mem[wa[j]][b*8 +: 8] <= wdata[j*DATA_W + b*8 +: 8];
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] v;
    rdata = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = raddr[i*ADDR_W +: ADDR_W];
      v  = mem[ra];
`ifdef REGFILE_BYPASS_EN
      // Same byte order as the write loop, so forwarding matches the collision priority.
      if (rst_n)
        for (int j = 0; j < NUM_WR; j++)
          for (int b = 0; b < BE_W; b++)
            if (wen[j] && wbe[j*BE_W + b] && wa[j] == ra)
              v[b*8 +: 8] = wdata[j*DATA_W + b*8 +: 8];
`endif
      if (ZERO_REG != 0 && ra == '0) v = '0;
      rdata[i*DATA_W +: DATA_W] = v;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wclr     (wclr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .raddr    (raddr),
    .rbusy    (rbusy),
    .busy_vec (busy_vec)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: reference model plus expected-read queue.
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW = 32, AW = 4, NR = 2, NW = 2, ZR = 1, DEPTH = 16;

  logic           clk, rst_n;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic [NW-1:0]    wen;
  logic [NW*AW-1:0] waddr;
  logic [NW*4-1:0]  wbe;
  logic [NW*DW-1:0] wdata;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic [DEPTH-1:0] busy_vec;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(ZR)) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        busy;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  logic [31:0] mem_m [DEPTH];
  logic [15:0] busy_m;
  logic [31:0] last_rd0;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'hCAFEF00D;
`else
  localparam logic [31:0] BYP_EXP = 32'h01020304;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_next_data(input logic [3:0] a);
    logic [31:0] v;
    v = mem_m[a];
    for (int j = 0; j < NW; j++)
      for (int b = 0; b < 4; b++)
        if (wen[j] && wbe[j*4+b] && waddr[j*AW +: AW] == a) v[b*8 +: 8] = wdata[j*DW + b*8 +: 8];
    return (a == 4'd0) ? 32'h0 : v;
  endfunction

  function automatic logic m_next_busy(input logic [3:0] a);
    logic bz;
    bz = busy_m[a];
    for (int j = 0; j < NW; j++)
      if (wen[j] && waddr[j*AW +: AW] == a) bz = 1'b0;
    if (rsv_en && rsv_addr == a) bz = 1'b1;
    return (a == 4'd0) ? 1'b0 : bz;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) mem_m[r] = '0;
    busy_m = '0;
  endtask

  // One clock: drive at/after negedge, check reads before the edge, check busy_vec after it.
  task automatic step(input logic [1:0] we, input logic [3:0] wa0, input logic [3:0] wa1,
                      input be_t be0, input be_t be1, input logic [31:0] wd0, input logic [31:0] wd1,
                      input logic rv, input logic [3:0] rva, input logic [3:0] ra0, input logic [3:0] ra1);
    logic [31:0] nd [DEPTH];
    logic [15:0] nb;
    rd_exp_t     e;
    wen = we; waddr = {wa1, wa0}; wbe = {be1, be0}; wdata = {wd1, wd0};
    rsv_en = rv; rsv_addr = rva; raddr = {ra1, ra0};
    #1;
    for (int i = 0; i < NR; i++) begin
      e.addr = raddr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      e.data = m_next_data(e.addr);
      e.busy = m_next_busy(e.addr);
`else
      e.data = (e.addr == 4'd0) ? 32'h0 : mem_m[e.addr];
      e.busy = (e.addr == 4'd0) ? 1'b0 : busy_m[e.addr];
`endif
      exp_q.push_back(e);
    end
    for (int a = 0; a < DEPTH; a++) begin
      nd[a] = m_next_data(4'(a));
      nb[a] = m_next_busy(4'(a));
    end
    last_rd0 = rdata[31:0];
    for (int i = 0; i < NR; i++) begin
      e = exp_q.pop_front();
      check($sformatf("rdata%0d[r%0d]", i, e.addr), 64'(rdata[i*DW +: DW]), 64'(e.data));
      check($sformatf("rbusy%0d[r%0d]", i, e.addr), 64'(rbusy[i]), 64'(e.busy));
    end
    @(posedge clk);
    for (int a = 0; a < DEPTH; a++) mem_m[a] = nd[a];
    busy_m = nb;
    @(negedge clk);
    check("busy_vec", 64'(busy_vec), 64'(busy_m));
  endtask

  task automatic expect_r(input string tag, input logic [3:0] a, input logic [31:0] d);
    wen = '0; rsv_en = 1'b0; raddr[3:0] = a;
    #1;
    check(tag, 64'(rdata[31:0]), 64'(d));
  endtask

  initial begin
    rst_n = 1'b0; wen = '0; waddr = '0; wbe = '0; wdata = '0;
    rsv_en = 1'b0; rsv_addr = '0; raddr = '0; last_rd0 = '0;
    model_reset();
    #1;

    // Writes and reservations during reset must be ignored.
    for (int c = 0; c < 4; c++) begin
      wen = (c % 2 == 1) ? 2'b11 : 2'b00;
      waddr = {4'd6, 4'd5}; wbe = '1; wdata = {32'h55555555, 32'hAAAAAAAA};
      rsv_en = 1'b1; rsv_addr = 4'd5; raddr = {4'd6, 4'd5};
      #1;
      check("reset_rdata0", 64'(rdata[31:0]), 64'h0);
      check("reset_rdata1", 64'(rdata[63:32]), 64'h0);
      check("reset_busy_vec", 64'(busy_vec), 64'h0);
      @(negedge clk);
    end
    rst_n = 1'b1;

    step(2'b01, 4'd5, 4'd0, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0, 1'b0, 4'd0, 4'd5, 4'd5);
    expect_r("r5_after_reset", 4'd5, 32'hDEADBEEF);

    step(2'b01, 4'd3, 4'd0, 4'hF, 4'h0, 32'h11223344, 32'h0, 1'b0, 4'd0, 4'd3, 4'd5);
    step(2'b01, 4'd3, 4'd0, 4'h5, 4'h0, 32'hAABBCCDD, 32'h0, 1'b0, 4'd0, 4'd3, 4'd3);
    expect_r("byte_enable", 4'd3, 32'h11BB33DD);

    step(2'b11, 4'd7, 4'd7, 4'hF, 4'hC, 32'h000000FF, 32'hABCD0000, 1'b0, 4'd0, 4'd7, 4'd7);
    expect_r("collision", 4'd7, 32'hABCD00FF);

    step(2'b00, 4'd0, 4'd0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 4'd9, 4'd9, 4'd9);
    check("rsv_sets_busy", 64'(busy_vec[9]), 64'h1);
    step(2'b01, 4'd9, 4'd0, 4'hF, 4'h0, 32'h12121212, 32'h0, 1'b1, 4'd9, 4'd9, 4'd9);
    check("rsv_beats_write", 64'(busy_vec[9]), 64'h1);
    step(2'b10, 4'd0, 4'd9, 4'h0, 4'hF, 32'h0, 32'h34343434, 1'b0, 4'd0, 4'd9, 4'd9);
    check("write_clears_busy", 64'(busy_vec[9]), 64'h0);

    // wen with no byte enables: data unchanged but busy still cleared.
    step(2'b00, 4'd0, 4'd0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 4'd3, 4'd3, 4'd9);
    step(2'b01, 4'd3, 4'd0, 4'h0, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 4'd0, 4'd3, 4'd3);
    expect_r("wbe0_keeps_data", 4'd3, 32'h11BB33DD);
    check("wbe0_clears_busy", 64'(busy_vec[3]), 64'h0);

    step(2'b01, 4'd0, 4'd0, 4'hF, 4'h0, 32'h12345678, 32'h0, 1'b1, 4'd0, 4'd0, 4'd0);
    expect_r("zero_reg_data", 4'd0, 32'h0);
    check("zero_reg_rbusy", 64'(rbusy[0]), 64'h0);
    check("zero_reg_busy_vec", 64'(busy_vec[0]), 64'h0);

    step(2'b01, 4'd4, 4'd0, 4'hF, 4'h0, 32'h01020304, 32'h0, 1'b0, 4'd0, 4'd1, 4'd2);
    step(2'b01, 4'd4, 4'd0, 4'hF, 4'h0, 32'hCAFEF00D, 32'h0, 1'b0, 4'd0, 4'd4, 4'd4);
    check("bypass_same_cycle", 64'(last_rd0), 64'(BYP_EXP));
    expect_r("bypass_next_cycle", 4'd4, 32'hCAFEF00D);

    for (int k = 0; k < 60; k++)
      step(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom, $urandom,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    // Asynchronous reset in the middle of a cycle carrying writes and a reservation.
    wen = 2'b11; waddr = {4'd8, 4'd4}; wbe = '1; wdata = {32'h77777777, 32'h66666666};
    rsv_en = 1'b1; rsv_addr = 4'd8; raddr = {4'd7, 4'd4};
    #2 rst_n = 1'b0;
    #1;
    check("midreset_rdata0", 64'(rdata[31:0]), 64'h0);
    check("midreset_rdata1", 64'(rdata[63:32]), 64'h0);
    check("midreset_busy_vec", 64'(busy_vec), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b00, 4'd0, 4'd0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd4, 4'd8);
    expect_r("after_midreset_r7", 4'd7, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
